clock_div_multi: RTL and testbench
==================================

Name: clock_div_multi

Overview:
- Parametrised N-channel clock/tick generator for the avionics timing tree; successor to the fixed single-ratio dividers.
- Each channel divides the shared input clock by a runtime-programmable integer ratio. It produces a near-50% divided clock and a one-cycle period-start tick, which downstream logic uses as a clock enable.
- Ratio updates are glitch-free: they are shadowed and applied only at a period boundary.
- Sits beside the oscillator input and feeds sensor sampling, UART baud and housekeeping timers.

Parameters:
- NUM_CH, 4, number of independent channels (1..16)
- CNT_W, 17, width of divisor and per-channel counter
- DEFAULT_DIV, 1000, full-period divisor loaded at reset into every channel (1 MHz in -> 1 kHz out)

Ports:
- CLK_IN  input  1  shared input clock; all logic on rising edge
- RESET  input  1  reset; synchronous, active-high
- CH_EN  input  NUM_CH  per-channel run enable
- DIV_WR  input  1  one-cycle divisor write strobe
- DIV_CH  input  max(1,clog2(NUM_CH))  target channel for write
- DIV_VAL  input  CNT_W  new full-period divisor
- CLK_OUT  output  NUM_CH  divided clock per channel (registered)
- TICK_OUT  output  NUM_CH  one-cycle period-start pulse per channel (registered)

Behaviour:
- Reset (RESET=1 at rising edge), all channels:
  - state IDLE, cnt=0
  - div_act=DEFAULT_DIV, pend_valid=0
  - CLK_OUT=0, TICK_OUT=0
  - Reset mid-period aborts immediately; CH_EN still high after reset release restarts per the IDLE rule.
- Effective divisor: D = max(DIV_VAL, 2). Values 0 and 1 are clamped to 2 at write time. Upper bound is 2^CNT_W-1.
- High phase H = ceil(D/2), low phase D-H. Example: D=5 gives 3 high, 2 low.
- Per-channel FSM, IDLE and RUN:
  - IDLE: CLK_OUT=0, TICK_OUT=0, cnt held 0. If CH_EN=1 at an edge: go to RUN, cnt<=0, div_act<=pending if pend_valid, CLK_OUT<=1, TICK_OUT<=1. First rising output is 1 cycle after enable is sampled.
  - RUN, CH_EN=1: if cnt==div_act-1, wrap: cnt<=0, load pending if valid, CLK_OUT<=1, TICK_OUT<=1. Otherwise cnt<=cnt+1, CLK_OUT<=(cnt+1 < H), TICK_OUT<=0.
  - RUN, CH_EN=0: go to IDLE; CLK_OUT and TICK_OUT go 0 next cycle. A partial period is truncated, never stretched. pend_valid is retained.
- TICK_OUT is high exactly in the cycle CLK_OUT rises, once per D cycles.
- Divisor writes:
  - DIV_WR=1 stores clamp(DIV_VAL) into the pending register of channel DIV_CH and sets pend_valid.
  - Multiple writes before a boundary: last wins.
  - A write in the same cycle as that channel's wrap or IDLE->RUN takes effect at that boundary (bypass); the new period uses the new D.
  - DIV_CH >= NUM_CH: write ignored.
- Channels are fully independent; there is no phase relation after differing enable times.
- Counter arithmetic is unsigned CNT_W bits; cnt never exceeds div_act-1, so there is no overflow.

Optional Feature:
- Macro: CLOCK_DIV_PHASE_ALIGN_EN.
- Defined: adds input SYNC_IN (1 bit). SYNC_IN=1 forces every channel in RUN to the wrap action (cnt<=0, load pending, CLK_OUT<=1, TICK_OUT<=1) in the same cycle, phase-aligning all channels. IDLE channels are unaffected. SYNC_IN has priority over normal counting; RESET has priority over SYNC_IN.
- Undefined: the port is absent and there is no alignment logic.

Decomposition:
- Package clock_div_pkg holds:
  - DIV_MIN=2 constant
  - state encoding (IDLE, RUN)
  - function clamp_div
  - function high_phase (ceil(D/2))
- One sub-module, clock_div_ch: the single-channel FSM, counter, shadow register and output registers. Instantiated NUM_CH times via generate.
- The top holds write-address decode and SYNC_IN fan-out.

Test Plan:
- Reset, CH_EN[0]=1, defaults -> CLK_OUT[0] 500 cycles high, 500 low; TICK_OUT[0] every 1000 cycles, coincident with the rising edge; first rise 1 cycle after enable.
- Write DIV_VAL=5 to ch1, then enable -> pattern 1,1,1,0,0 repeating; tick every 5 cycles. Write DIV_VAL=0 -> period 2 (1 high, 1 low).
- Ch0 running D=1000, write DIV_VAL=10 at cnt=300 -> current 1000-cycle period completes unchanged, then 10-cycle periods. Write coincident with the wrap cycle -> the very next period is 10.
- Two writes (20, then 30) to ch2 before its boundary -> next period 30. Write with DIV_CH=NUM_CH -> no channel changes.
- Deassert CH_EN mid-high-phase -> CLK_OUT=0 next cycle, no tick. Reassert -> fresh full period. Assert RESET mid-period -> all outputs 0 next cycle, div_act back to 1000.
- With CLOCK_DIV_PHASE_ALIGN_EN: ch0 D=4 and ch1 D=6 running out of phase, pulse SYNC_IN -> both TICK_OUT high the next cycle, identical phase thereafter at their ratios.

Source files
------------

// File: rtl/clock_div_pkg.sv
// Shared definitions for the multi-channel clock divider: minimum divisor,
// channel state encoding and the divisor helper functions.
package clock_div_pkg;

    localparam int DIV_MIN = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } ch_state_e;

    // Divisors below DIV_MIN cannot produce both a high and a low phase.
    function automatic logic [31:0] clamp_div(input logic [31:0] v);
        return (v < 32'(DIV_MIN)) ? 32'(DIV_MIN) : v;
    endfunction

    // High phase length ceil(D/2); odd divisors spend the extra cycle high.
    function automatic logic [31:0] high_phase(input logic [31:0] d);
        return (d >> 1) + {31'd0, d[0]};
    endfunction

endpackage

// File: rtl/clock_div_multi_ch.sv
// Single divider channel: run FSM, period counter, shadowed divisor and
// registered clock/tick outputs.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | channel stopped, outputs low, counter held at 0
// ST_RUN  | counting 0..div_act-1, a new period starts at every wrap
module clock_div_ch
    import clock_div_pkg::*;
#(
    parameter int CNT_W       = 17,
    parameter int DEFAULT_DIV = 1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             sync_i,
    input  logic             wr_i,
    input  logic [CNT_W-1:0] wr_val_i,
    output logic             clk_o,
    output logic             tick_o
);

    ch_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_act_q, div_act_d;
    logic [CNT_W-1:0] pend_q, pend_d;
    logic             pend_valid_q, pend_valid_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;

    logic             boundary;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] high_len;

    // Next-state: count within a period, start a new one at wrap/enable/sync,
    // and fold a same-cycle divisor write straight into the new period.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        div_act_d    = div_act_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        clk_d        = 1'b0;
        tick_d       = 1'b0;
        boundary     = 1'b0;
        cnt_inc      = cnt_q + CNT_W'(1);
        high_len     = CNT_W'(high_phase(32'(div_act_q)));

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (en_i) boundary = 1'b1;
            end
            ST_RUN: begin
                if (!en_i) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (sync_i || (cnt_q == div_act_q - CNT_W'(1))) begin
                    boundary = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                    clk_d = (cnt_inc < high_len);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        if (boundary) begin
            state_d      = ST_RUN;
            cnt_d        = '0;
            clk_d        = 1'b1;
            tick_d       = 1'b1;
            pend_valid_d = 1'b0;
            if (wr_i) begin
                div_act_d = wr_val_i;
            end else if (pend_valid_q) begin
                div_act_d = pend_q;
            end
        end else if (wr_i) begin
            pend_d       = wr_val_i;
            pend_valid_d = 1'b1;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            div_act_q    <= CNT_W'(DEFAULT_DIV);
            pend_q       <= CNT_W'(DEFAULT_DIV);
            pend_valid_q <= 1'b0;
            clk_q        <= 1'b0;
            tick_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            div_act_q    <= div_act_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            clk_q        <= clk_d;
            tick_q       <= tick_d;
        end
    end

    assign clk_o  = clk_q;
    assign tick_o = tick_q;

endmodule

// File: rtl/clock_div_multi.sv
// N-channel programmable clock/tick divider. Holds divisor write decode,
// divisor clamping and the optional SYNC_IN fan-out.
// Optional feature macro: CLOCK_DIV_PHASE_ALIGN_EN (adds SYNC_IN phase alignment).
module clock_div_multi
    import clock_div_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 17,
    parameter int DEFAULT_DIV = 1000,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              CLK_IN,
    input  logic              RESET,
    input  logic [NUM_CH-1:0] CH_EN,
    input  logic              DIV_WR,
    input  logic [CH_W-1:0]   DIV_CH,
    input  logic [CNT_W-1:0]  DIV_VAL,
`ifdef CLOCK_DIV_PHASE_ALIGN_EN
    input  logic              SYNC_IN,
`endif
    output logic [NUM_CH-1:0] CLK_OUT,
    output logic [NUM_CH-1:0] TICK_OUT
);

    logic [CNT_W-1:0] div_val_clamped;
    logic             sync_all;

    // Clamp once here so every channel stores an already-legal divisor.
    always_comb begin
        div_val_clamped = CNT_W'(clamp_div(32'(DIV_VAL)));
    end

`ifdef CLOCK_DIV_PHASE_ALIGN_EN
    assign sync_all = SYNC_IN;
`else
    assign sync_all = 1'b0;
`endif

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic wr_sel;

        // Out-of-range DIV_CH matches no channel, so such writes vanish.
        always_comb begin
            wr_sel = DIV_WR && (32'(DIV_CH) == i);
        end

        clock_div_ch #(
            .CNT_W       (CNT_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .clk      (CLK_IN),
            .rst      (RESET),
            .en_i     (CH_EN[i]),
            .sync_i   (sync_all),
            .wr_i     (wr_sel),
            .wr_val_i (div_val_clamped),
            .clk_o    (CLK_OUT[i]),
            .tick_o   (TICK_OUT[i])
        );
    end

endmodule

// File: tb/tb_clock_div_multi.sv
// Scoreboard bench for clock_div_multi: the stimulus process predicts each
// cycle's outputs from a time-stamp model and queues them; the monitor pops
// and compares after every rising edge.
module tb_clock_div_multi;

    localparam int NCH   = 3;
    localparam int CW    = 17;
    localparam int DDEF  = 1000;
    localparam int CHW   = 2;

    logic            CLK_IN = 1'b0;
    logic            RESET  = 1'b1;
    logic [NCH-1:0]  CH_EN  = '0;
    logic            DIV_WR = 1'b0;
    logic [CHW-1:0]  DIV_CH = '0;
    logic [CW-1:0]   DIV_VAL = '0;
    logic            SYNC_IN = 1'b0;
    logic [NCH-1:0]  CLK_OUT, TICK_OUT;

    clock_div_multi #(.NUM_CH(NCH), .CNT_W(CW), .DEFAULT_DIV(DDEF)) dut (
        .CLK_IN   (CLK_IN),
        .RESET    (RESET),
        .CH_EN    (CH_EN),
        .DIV_WR   (DIV_WR),
        .DIV_CH   (DIV_CH),
        .DIV_VAL  (DIV_VAL),
`ifdef CLOCK_DIV_PHASE_ALIGN_EN
        .SYNC_IN  (SYNC_IN),
`endif
        .CLK_OUT  (CLK_OUT),
        .TICK_OUT (TICK_OUT)
    );

    always #5 CLK_IN = ~CLK_IN;

    int n_tests = 0;
    int n_fail  = 0;
    logic [2*NCH-1:0] exp_q[$];

    // Reference model: each running channel remembers the cycle its current
    // period began and its divisor; outputs follow from elapsed time.
    int now = 0;
    bit m_run [NCH];
    int m_start [NCH];
    int m_d [NCH];
    int m_pend [NCH];
    bit m_pv [NCH];
    logic [NCH-1:0] en_v = '0;

    task automatic step(input bit rst, input bit wr, input int ch, input int val, input bit sync);
        logic [NCH-1:0] ec, et;
        int cv;
        RESET   = rst;
        CH_EN   = en_v;
        DIV_WR  = wr;
        DIV_CH  = CHW'(ch);
        DIV_VAL = CW'(val);
        SYNC_IN = sync;
        now++;
        cv = (val < 2) ? 2 : val;
        ec = '0;
        et = '0;
        for (int i = 0; i < NCH; i++) begin
            bit wv, newp;
            wv = wr && (ch == i);
            newp = 0;
            if (rst) begin
                m_run[i] = 0;
                m_d[i]   = DDEF;
                m_pv[i]  = 0;
            end else begin
                if (!en_v[i]) begin
                    m_run[i] = 0;
                end else if (!m_run[i] || sync || (now - m_start[i] == m_d[i])) begin
                    newp = 1;
                end
`ifndef CLOCK_DIV_PHASE_ALIGN_EN
                if (sync) newp = newp; // sync unused without the feature
`endif
                if (newp) begin
                    m_run[i]   = 1;
                    m_start[i] = now;
                    if (wv) m_d[i] = cv;
                    else if (m_pv[i]) m_d[i] = m_pend[i];
                    m_pv[i] = 0;
                end else if (wv) begin
                    m_pend[i] = cv;
                    m_pv[i]   = 1;
                end
            end
            if (m_run[i] && !rst) begin
                int age;
                age   = now - m_start[i];
                ec[i] = (age < (m_d[i] + 1) / 2);
                et[i] = (age == 0);
            end
        end
        exp_q.push_back({ec, et});
        @(negedge CLK_IN);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0);
    endtask

    // Bounded wait until channel c's next edge would start a new period.
    task automatic wait_wrap_edge(input int c);
        int guard;
        guard = 0;
        while (!(m_run[c] && (now + 1 - m_start[c] == m_d[c])) && guard < 3000) begin
            step(0, 0, 0, 0, 0);
            guard++;
        end
        if (guard >= 3000) begin
            n_tests++;
            n_fail++;
            $display("FAIL wrap_wait ch%0d: no wrap within bound, required within 3000 cycles", c);
        end
    endtask

    // Monitor: one queued prediction per rising edge, compared 1 time unit later.
    initial begin
        forever begin
            @(posedge CLK_IN);
            #1;
            if (exp_q.size() > 0) begin
                logic [2*NCH-1:0] e;
                e = exp_q.pop_front();
                n_tests++;
                if ({CLK_OUT, TICK_OUT} !== e) begin
                    n_fail++;
                    if (n_fail <= 20)
                        $display("FAIL outputs t=%0d: clk_out=%b tick_out=%b, required clk_out=%b tick_out=%b",
                                 $time, CLK_OUT, TICK_OUT, e[2*NCH-1:NCH], e[NCH-1:0]);
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < NCH; i++) begin
            m_run[i] = 0; m_start[i] = 0; m_d[i] = DDEF; m_pend[i] = DDEF; m_pv[i] = 0;
        end
        @(negedge CLK_IN);
        // reset, then ch0 with the default divisor for two full periods
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        idle(3);
        en_v[0] = 1'b1;
        idle(2050);

        // ch1: divide by 5, then by the clamped value 2
        step(0, 1, 1, 5, 0);
        en_v[1] = 1'b1;
        idle(22);
        step(0, 1, 1, 0, 0);
        idle(12);
        step(0, 1, 1, 1, 0);
        idle(8);

        // ch0: write mid-period, then a write coincident with the wrap
        while (!(now + 1 - m_start[0] == 300) && now < 4000) step(0, 0, 0, 0, 0);
        step(0, 1, 0, 10, 0);
        wait_wrap_edge(0);
        idle(25);
        wait_wrap_edge(0);
        step(0, 1, 0, 7, 0);
        idle(20);

        // ch2: last write wins; out-of-range channel write is dropped
        step(0, 1, 2, 20, 0);
        step(0, 1, 2, 30, 0);
        step(0, 1, 3, 3, 0);
        en_v[2] = 1'b1;
        idle(70);

        // disable mid-high-phase, re-enable, reset mid-period
        wait_wrap_edge(1);
        step(0, 1, 1, 9, 0);
        idle(2);
        en_v[1] = 1'b0;
        idle(5);
        en_v[1] = 1'b1;
        idle(25);
        idle(3);
        step(1, 0, 0, 0, 0);
        idle(1010);

`ifdef CLOCK_DIV_PHASE_ALIGN_EN
        // phase alignment: ch0 D=4 and ch1 D=6 started at different times
        en_v = '0;
        step(0, 1, 0, 4, 0);
        step(0, 1, 1, 6, 0);
        en_v[0] = 1'b1;
        idle(3);
        en_v[1] = 1'b1;
        idle(7);
        step(0, 0, 0, 0, 1);
        idle(30);
`endif

        // randomized traffic
        for (int k = 0; k < 9000; k++) begin
            bit r, w, s;
            int c, v;
            if ($urandom_range(0, 150) == 0) en_v[$urandom_range(0, NCH-1)] ^= 1'b1;
            r = ($urandom_range(0, 2500) == 0);
            w = ($urandom_range(0, 15) == 0);
            c = $urandom_range(0, 3);
            v = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 60) : $urandom_range(0, 12);
`ifdef CLOCK_DIV_PHASE_ALIGN_EN
            s = ($urandom_range(0, 250) == 0);
`else
            s = 1'b0;
`endif
            step(r, w, c, v, s);
        end

        idle(2);
        @(posedge CLK_IN);
        #2;
        n_tests++;
        if (exp_q.size() > 1) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, required at most 1", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
